// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: optional 4-word victim writeback, then 4-word allocate, then a one-cycle done pulse.
// Writeback is built only when CACHE_FILL_WB_EN is defined; otherwise every miss goes straight to allocate.
module cache_fill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   output logic              busy,
   output logic              fill_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        word_sel,
   output logic              line_we,
   output logic [1:0]        line_wsel,
   output logic [DATA_W-1:0] line_wdata
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, DONE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        cnt, cnt_nxt;
   // Only the line-base bits are kept; the low 4 address bits are always zero.
   logic [ADDR_W-5:0] miss_hi;

`ifdef CACHE_FILL_WB_EN
   logic [ADDR_W-5:0] victim_hi;
   logic              unused_bits;
   assign unused_bits = ^{miss_addr[3:0], victim_addr[3:0]};
`else
   logic              unused_bits;
   assign unused_bits = ^{miss_addr[3:0], victim_addr, victim_dirty};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         miss_hi <= '0;
`ifdef CACHE_FILL_WB_EN
         victim_hi <= '0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && miss_req) begin
            miss_hi <= miss_addr[ADDR_W-1:4];
`ifdef CACHE_FILL_WB_EN
            victim_hi <= victim_addr[ADDR_W-1:4];
`endif
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      busy       = (state != IDLE);
      fill_done  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      word_sel   = cnt;
      line_we    = 1'b0;
      line_wsel  = 2'd0;
      line_wdata = '0;
      case (state)
         IDLE: begin
            if (miss_req) begin
               cnt_nxt = 2'd0;
`ifdef CACHE_FILL_WB_EN
               state_nxt = victim_dirty ? WRITEBACK : ALLOCATE;
`else
               state_nxt = ALLOCATE;
`endif
            end
         end
`ifdef CACHE_FILL_WB_EN
         WRITEBACK: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {victim_hi, cnt, 2'b00};
            if (mem_ack) begin
               cnt_nxt = cnt + 2'd1;
               if (cnt == 2'd3) state_nxt = ALLOCATE;
            end
         end
`endif
         ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = {miss_hi, cnt, 2'b00};
            if (mem_ack) begin
               line_we    = 1'b1;
               line_wsel  = cnt;
               line_wdata = mem_rdata;
               cnt_nxt    = cnt + 2'd1;
               if (cnt == 2'd3) state_nxt = DONE;
            end
         end
         DONE: begin
            fill_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: stimulus pushes expected memory transfers, line writes and done cycles;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_cache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_req = 1'b0;
   logic [31:0] miss_addr = '0;
   logic        victim_dirty = 1'b0;
   logic [31:0] victim_addr = '0;
   logic        busy, fill_done, mem_req, mem_we;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata = 32'hDEAD_BEEF;
   logic [1:0]  word_sel;
   logic        line_we;
   logic [1:0]  line_wsel;
   logic [31:0] line_wdata;

   logic        resp_ack = 1'b0;
   logic        force_ack = 1'b0;
   logic        ack_en = 1'b1;
   int          stall_n = 0;
   int          wait_cnt = 0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  wsel;
   } mem_exp_t;

   typedef struct packed {
      logic [1:0]  wsel;
      logic [31:0] wdata;
   } line_exp_t;

   mem_exp_t  mem_q[$];
   line_exp_t line_q[$];
   int        done_q[$];

   assign mem_ack = resp_ack | force_ack;

   cache_fill_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr),
      .busy(busy), .fill_done(fill_done), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .word_sel(word_sel), .line_we(line_we), .line_wsel(line_wsel),
      .line_wdata(line_wdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory model: acks after stall_n wait cycles per word; read data is 0xA0 + word index.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (mem_req && ack_en) begin
            if (wait_cnt >= stall_n) begin
               resp_ack  = 1'b1;
               wait_cnt  = 0;
               mem_rdata = 32'hA0 + {30'd0, mem_addr[3:2]};
            end else begin
               resp_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   logic        prev_pend = 1'b0;
   logic [35:0] snap = '0;

   always @(negedge clk) begin
      mem_exp_t  me;
      line_exp_t le;
      int        dc;
      if (mem_req && mem_ack) begin
         if (mem_q.size() == 0) check("mem_xfer_unexpected", {31'd0, mem_we, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            me = mem_q.pop_front();
            check("mem_we", {63'd0, mem_we}, {63'd0, me.we});
            check("mem_addr", {32'd0, mem_addr}, {32'd0, me.addr});
            if (me.we) check("word_sel", {62'd0, word_sel}, {62'd0, me.wsel});
         end
      end
      if (line_we) begin
         if (line_q.size() == 0) check("line_we_spurious", {62'd0, line_wsel}, 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            le = line_q.pop_front();
            check("line_wsel", {62'd0, line_wsel}, {62'd0, le.wsel});
            check("line_wdata", {32'd0, line_wdata}, {32'd0, le.wdata});
         end
      end
      if (fill_done) begin
         if (done_q.size() == 0) check("fill_done_spurious", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            dc = done_q.pop_front();
            check("fill_done_cycle", 64'(cyc), 64'(dc));
         end
      end
      if (prev_pend) check("stall_hold", {28'd0, mem_req, mem_we, word_sel, mem_addr}, {28'd0, snap});
      prev_pend = mem_req && !mem_ack && !rst;
      snap      = {mem_req, mem_we, word_sel, mem_addr};
   end

   task automatic push_reads(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem_q.push_back('{we: 1'b0, addr: base + 32'(4 * i), wsel: 2'(i)});
         line_q.push_back('{wsel: 2'(i), wdata: 32'hA0 + 32'(i)});
      end
   endtask

   // Presents miss_req for one cycle (or holds it when hold=1); returns the issue cycle.
   task automatic issue_miss(input logic [31:0] ma, input logic vd, input logic [31:0] va,
                             input bit hold, output int c);
      @(posedge clk);
      #1;
      miss_req     = 1'b1;
      miss_addr    = ma;
      victim_dirty = vd;
      victim_addr  = va;
      c            = cyc;
      if (!hold) begin
         @(posedge clk);
         #1;
         miss_req = 1'b0;
      end
   endtask

   task automatic wait_done(input int bound);
      bit seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         if (fill_done) seen = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_done: no fill_done within %0d cycles", bound);
      end
   endtask

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_outs", {59'd0, mem_req, mem_we, fill_done, line_we, 1'b0}, 64'd0);
      check("rst_addr_sel", {30'd0, word_sel, mem_addr}, 64'd0);
      rst = 1'b0;

      // Clean miss, ack every cycle.
      stall_n = 0;
      issue_miss(32'h0000_1234, 1'b0, 32'h0000_9990, 0, c);
      push_reads(32'h0000_1230, 4);
      done_q.push_back(c + 5);
      check("busy_in_fill", {63'd0, busy}, 64'd1);
      wait_done(40);
      repeat (2) @(posedge clk);

      // Dirty victim.
      issue_miss(32'h0000_2468, 1'b1, 32'h0000_5670, 0, c);
`ifdef CACHE_FILL_WB_EN
      for (int i = 0; i < 4; i++)
         mem_q.push_back('{we: 1'b1, addr: 32'h0000_5670 + 32'(4 * i), wsel: 2'(i)});
      push_reads(32'h0000_2460, 4);
      done_q.push_back(c + 9);
`else
      push_reads(32'h0000_2460, 4);
      done_q.push_back(c + 5);
`endif
      wait_done(40);
      repeat (2) @(posedge clk);

      // Three stall cycles before every ack.
      stall_n = 3;
      issue_miss(32'h0000_ABCF, 1'b0, 32'h0, 0, c);
      push_reads(32'h0000_ABC0, 4);
      done_q.push_back(c + 17);
      wait_done(60);
      stall_n = 0;
      repeat (2) @(posedge clk);

      // Reset after the second allocate ack, then a fresh miss.
      issue_miss(32'h0000_3000, 1'b0, 32'h0, 0, c);
      push_reads(32'h0000_3000, 2);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      ack_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      ack_en = 1'b1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_outs", {61'd0, mem_req, fill_done, line_we}, 64'd0);
      check("abort_word_sel", {62'd0, word_sel}, 64'd0);
      issue_miss(32'h0000_4008, 1'b0, 32'h0, 0, c);
      push_reads(32'h0000_4000, 4);
      done_q.push_back(c + 5);
      wait_done(40);
      repeat (2) @(posedge clk);

      // Acks in IDLE are ignored; miss_req held through the fill gives one fill.
      #1;
      force_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      force_ack = 1'b0;
      issue_miss(32'h0000_7010, 1'b0, 32'h0, 1, c);
      push_reads(32'h0000_7010, 4);
      done_q.push_back(c + 5);
      wait_done(40);
      miss_req = 1'b0;
      @(posedge clk);
      #1;
      force_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      force_ack = 1'b0;
      check("idle_after_held", {63'd0, busy}, 64'd0);

      repeat (4) @(posedge clk);
      #1;
      check("mem_q_left", 64'(mem_q.size()), 64'd0);
      check("line_q_left", 64'(line_q.size()), 64'd0);
      check("done_q_left", 64'(done_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
